// File: rtl/decoder_grant_arbiter.sv
// Round-robin arbiter sharing a 4:16 decoder's select lines among 16 requesters.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD forced-release counter and timeout pulse.
module decoder_grant_arbiter #(
    parameter int unsigned NREQ     = 16,
    parameter int unsigned IDXW     = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [IDXW-1:0] sel,
    output logic            en,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StRelease = 2'd2
    } state_e;

    // Elaboration-time parameter sanity checks.
    if (NREQ != (1 << IDXW)) begin : g_bad_nreq
        $error("NREQ must equal 2**IDXW");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD must be in 1..255");
    end

    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] sel_q, sel_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic [IDXW-1:0] winner;
    logic            found;
    logic [IDXW-1:0] cand;
    logic            owner_release;
    logic            hold_expired;

    // Search ptr+1 .. ptr+16 (mod NREQ); iterating downward lets the nearest hit win.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = ptr_q + IDXW'(k);
            if (req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign owner_release = done || !req[sel_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;

    assign hold_expired = (hold_q == 8'(MAX_HOLD - 1));

    always_comb begin
        hold_d = '0;
        if (state_q == StGrant && !owner_release && !hold_expired) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        en_d      = en_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (found) begin
                    sel_d   = winner;
                    ptr_d   = winner;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (owner_release || hold_expired) begin
                    en_d      = 1'b0;
                    busy_d    = 1'b1;
                    // Owner-initiated release wins a tie; no timeout pulse then.
                    timeout_d = !owner_release;
                    state_d   = StRelease;
                end
            end
            StRelease: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= IDXW'(NREQ - 1);
            sel_q     <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel     = sel_q;
    assign en      = en_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
